in_align_fifo: RTL and testbench
================================

IN_ALIGN_FIFO -- requirements
Module: in_align_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning per-row FIFO depth and the maximum sub_scale_M.
REQ-002 SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from Multiply_ctrl; begins a load.
- sub_scale_M  in  8  elements per row.
- sub_scale_P  in  8  active rows.
- in_valid  in  1  input stream valid, from In_ctrl.
- in_data  in  32  input stream data.
- in_ready  out  1  stream ready.
- mult_ready  in  1  Multiply_8x8 can accept this cycle.
- valid_put0..valid_put7  out  1 each  per-row data valid to Multiply_8x8.
- data_put0..data_put7  out  32 each  per-row data to Multiply_8x8.
- feed_done  out  1  one-cycle pulse when drain completes.

Function
REQ-003 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-004 In IDLE, start SHALL latch M and P and enter LOAD only if 1<=M<=DEPTH and 1<=P<=8; otherwise start is ignored.
REQ-005 start SHALL be ignored in every state except IDLE.
REQ-006 in_ready SHALL equal (state==LOAD); a transfer occurs on in_valid&&in_ready.
REQ-007 Transfer k (0-based) SHALL be written to row FIFO (k mod P); the row pointer wraps from P-1 to 0.
REQ-008 The load counter SHALL be 16 bits wide; compare against the latched M*P, computed as a 16-bit product.
REQ-009 When transfer M*P-1 occurs, the next state SHALL be DRAIN, so in_ready is low from the following cycle.
REQ-010 DRAIN SHALL keep a skew counter t, starting at 0, that advances only on cycles where mult_ready=1.
- Row i SHALL be read at t when i<P and i<=t<i+M.
- The counter ends at t=M+P-2.
REQ-011 valid_put_i and data_put_i SHALL be registered with 1-cycle latency.
- They are high and carry the FIFO word on the cycle after the read.
- Otherwise valid_put_i is low and data_put_i holds its last value.
REQ-012 When mult_ready=0, no FIFO SHALL be read and all valid_put SHALL be low on the next cycle.
REQ-013 Rows i>=P SHALL never assert valid_put_i.
REQ-014 After the final read, the state SHALL move to DONE.
- DONE asserts feed_done for exactly one cycle, coincident with the last valid_put.
- DONE then returns to IDLE.
REQ-015 All row FIFOs SHALL be empty on return to IDLE; per-row write and read counts SHALL both equal M.
REQ-016 Per-row FIFO overflow or underflow SHALL be impossible by construction; a full write or empty read is a design error that assertions flag.

Reset
REQ-017 While rst=0, the block SHALL hold the following values, asynchronously:
- state=IDLE; all counters and row pointer =0; FIFO pointers cleared.
- in_ready=0, valid_put*=0, data_put*=0, feed_done=0.
REQ-018 Reset asserted mid-LOAD or mid-DRAIN SHALL discard all buffered data; after release the block waits in IDLE for start.

Structure
REQ-019 A shared package SHALL hold the state encoding, the row count constant (8), and the data width constant (32).
REQ-020 The block SHALL instantiate eight copies of one sub-module, feed_row_fifo.
- Synchronous, DEPTH x 32.
- Registered dout with 1-cycle read latency.
- Provides empty and full flags.
- Same clk/rst.

Verification
REQ-021 The bench SHALL cover:
- M=4, P=8, stream 0..31 with in_valid always high and mult_ready=1 -> row i receives i, i+8, i+16, i+24. valid_put_i first rises i+1 cycles after DRAIN entry. feed_done pulses once, 11 cycles after DRAIN entry.
- M=3, P=2 with in_valid toggling 1/0 -> in_ready is low after the 6th transfer. Row0 gets 0,2,4; row1 gets 1,3,5. valid_put2..7 never assert.
- M=16, P=8 with mult_ready low every third cycle of DRAIN -> each stall cycle yields all valid_put low. Output order is unchanged; 128 words are delivered; no FIFO full or empty violation.
- start with M=0, then M=17, then P=9 -> the block stays in IDLE and in_ready stays 0. start with M=1, P=1 -> one transfer, one valid_put0 pulse, feed_done.
- rst pulsed low during DRAIN at t=2 (M=8, P=8) -> all outputs are 0 immediately. A fresh load with M=2, P=2 then delivers only new data.
- start pulsed during LOAD -> ignored; the latched M and P are unchanged.

Source files
------------

// File: rtl/in_align_fifo_pkg.sv
// Shared definitions for the input-alignment feeder: row count, data width and
// the controller state encoding.
package in_align_fifo_pkg;

   localparam int NUM_ROWS = 8;
   localparam int DATA_W   = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } feed_state_e;

endpackage

// File: rtl/in_align_fifo_row.sv
// Single row buffer: synchronous DEPTH x DATA_W FIFO with a registered read port
// (dout updates one cycle after rd_en and holds its value otherwise).
module feed_row_fifo
   import in_align_fifo_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (wr_en) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
         if (rd_en) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (!rst) !(wr_en && full));
   assert property (@(posedge clk) disable iff (!rst) !(rd_en && empty));

endmodule

// File: rtl/in_align_fifo.sv
// Input alignment feeder: distributes a stream round-robin over P row FIFOs, then
// drains them with a one-cycle-per-row skew into the 8x8 multiplier array.
//
//   state | meaning
//   IDLE  | waiting for a start with legal M and P
//   LOAD  | accepting M*P stream words, row pointer cycling 0..P-1
//   DRAIN | skewed read-out, advancing only when mult_ready
//   DONE  | last words on valid_put, feed_done pulse
module in_align_fifo
   import in_align_fifo_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  sub_scale_M,
   input  logic [7:0]  sub_scale_P,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   input  logic        mult_ready,
   output logic        valid_put0,
   output logic        valid_put1,
   output logic        valid_put2,
   output logic        valid_put3,
   output logic        valid_put4,
   output logic        valid_put5,
   output logic        valid_put6,
   output logic        valid_put7,
   output logic [31:0] data_put0,
   output logic [31:0] data_put1,
   output logic [31:0] data_put2,
   output logic [31:0] data_put3,
   output logic [31:0] data_put4,
   output logic [31:0] data_put5,
   output logic [31:0] data_put6,
   output logic [31:0] data_put7,
   output logic        feed_done
);

   localparam logic [15:0] M_MAX = 16'(DEPTH);

   feed_state_e         state_q, state_d;
   logic [7:0]          m_q, p_q;
   logic [15:0]         mp_q, load_cnt_q, skew_q, last_t;
   logic [2:0]          row_ptr_q;
   logic [NUM_ROWS-1:0] wr_en, rd_en, empty, full, valid_q;
   logic [DATA_W-1:0]   dout [NUM_ROWS];
   logic                start_ok, xfer, last_xfer, last_read;

   assign start_ok  = start && (sub_scale_M != 8'd0) && ({8'd0, sub_scale_M} <= M_MAX)
                      && (sub_scale_P != 8'd0) && (sub_scale_P <= 8'(NUM_ROWS));
   assign in_ready  = (state_q == LOAD);
   assign xfer      = in_ready && in_valid;
   assign last_xfer = xfer && (load_cnt_q == mp_q - 16'd1);
   assign last_t    = {8'd0, m_q} + {8'd0, p_q} - 16'd2;
   assign last_read = (state_q == DRAIN) && mult_ready && (skew_q == last_t);
   assign feed_done = (state_q == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok)  state_d = LOAD;
         LOAD:    if (last_xfer) state_d = DRAIN;
         DRAIN:   if (last_read) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q        <= '0;
         p_q        <= '0;
         mp_q       <= '0;
         load_cnt_q <= '0;
         row_ptr_q  <= '0;
         skew_q     <= '0;
      end else begin
         if ((state_q == IDLE) && start_ok) begin
            m_q        <= sub_scale_M;
            p_q        <= sub_scale_P;
            mp_q       <= 16'(sub_scale_M) * 16'(sub_scale_P);
            load_cnt_q <= '0;
            row_ptr_q  <= '0;
            skew_q     <= '0;
         end
         if (xfer) begin
            load_cnt_q <= load_cnt_q + 16'd1;
            row_ptr_q  <= ({5'd0, row_ptr_q} == p_q - 8'd1) ? '0 : row_ptr_q + 3'd1;
         end
         if ((state_q == DRAIN) && mult_ready) skew_q <= skew_q + 16'd1;
      end
   end

   // Row i is live for skew steps i .. i+M-1, giving the diagonal wavefront.
   always_comb begin
      wr_en = '0;
      rd_en = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         wr_en[i] = xfer && (row_ptr_q == 3'(i));
         rd_en[i] = (state_q == DRAIN) && mult_ready && (8'(i) < p_q)
                    && (skew_q >= 16'(i)) && (skew_q < 16'(i) + {8'd0, m_q});
      end
   end

   for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
      feed_row_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .wr_en (wr_en[g]),
         .din   (in_data),
         .rd_en (rd_en[g]),
         .dout  (dout[g]),
         .empty (empty[g]),
         .full  (full[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) valid_q <= '0;
      else      valid_q <= rd_en;
   end

   assert property (@(posedge clk) disable iff (!rst) !(|(wr_en & full)));
   assert property (@(posedge clk) disable iff (!rst) (state_q == DONE) |-> (&empty));

   assign valid_put0 = valid_q[0];
   assign valid_put1 = valid_q[1];
   assign valid_put2 = valid_q[2];
   assign valid_put3 = valid_q[3];
   assign valid_put4 = valid_q[4];
   assign valid_put5 = valid_q[5];
   assign valid_put6 = valid_q[6];
   assign valid_put7 = valid_q[7];
   assign data_put0  = dout[0];
   assign data_put1  = dout[1];
   assign data_put2  = dout[2];
   assign data_put3  = dout[3];
   assign data_put4  = dout[4];
   assign data_put5  = dout[5];
   assign data_put6  = dout[6];
   assign data_put7  = dout[7];

endmodule

// File: tb/tb_in_align_fifo.sv
// Randomized bench for in_align_fifo; expected row contents and output timing come
// from a queue-per-row reference model driven by the same stimulus.
module tb_in_align_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  sub_scale_M = 8'd0;
   logic [7:0]  sub_scale_P = 8'd0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        mult_ready = 1'b0;
   logic        in_ready, feed_done;
   logic        valid_put0, valid_put1, valid_put2, valid_put3;
   logic        valid_put4, valid_put5, valid_put6, valid_put7;
   logic [31:0] data_put0, data_put1, data_put2, data_put3;
   logic [31:0] data_put4, data_put5, data_put6, data_put7;

   logic [7:0]  vp;
   logic [31:0] dp [8];

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] rowq [8][$];
   logic [31:0] exp_hold [8];

   in_align_fifo #(.DEPTH(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .sub_scale_M(sub_scale_M), .sub_scale_P(sub_scale_P),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mult_ready(mult_ready),
      .valid_put0(valid_put0), .valid_put1(valid_put1), .valid_put2(valid_put2), .valid_put3(valid_put3),
      .valid_put4(valid_put4), .valid_put5(valid_put5), .valid_put6(valid_put6), .valid_put7(valid_put7),
      .data_put0(data_put0), .data_put1(data_put1), .data_put2(data_put2), .data_put3(data_put3),
      .data_put4(data_put4), .data_put5(data_put5), .data_put6(data_put6), .data_put7(data_put7),
      .feed_done(feed_done)
   );

   assign vp = {valid_put7, valid_put6, valid_put5, valid_put4,
                valid_put3, valid_put2, valid_put1, valid_put0};
   assign dp[0] = data_put0;
   assign dp[1] = data_put1;
   assign dp[2] = data_put2;
   assign dp[3] = data_put3;
   assign dp[4] = data_put4;
   assign dp[5] = data_put5;
   assign dp[6] = data_put6;
   assign dp[7] = data_put7;

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, ":in_ready"}, in_ready, 0);
      check_val({tag, ":feed_done"}, feed_done, 0);
      check_val({tag, ":valid_put"}, vp, 0);
      for (int i = 0; i < 8; i++) check_val($sformatf("%s:data_put%0d", tag, i), dp[i], 0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         rowq[i].delete();
         exp_hold[i] = 32'd0;
      end
   endtask

   // vmode: 0 always valid, 1 toggling, 2 random.  smode: 0 always ready, 1 low every 3rd, 2 random.
   task automatic run_case(input string name, input int m, input int p, input int vmode,
                           input int smode, input bit seq_data, input int abort_t,
                           input bit start_in_load);
      int          mp, xfers, t, idx, done_idx;
      int          first_rise [8];
      bit          nxt_v [8];
      logic [31:0] nxt_d [8];
      bit          done_nxt, finished, aborted;
      mp = m * p;
      xfers = 0;
      t = 0;
      done_idx = -1;
      finished = 0;
      aborted = 0;
      done_nxt = 0;
      for (int i = 0; i < 8; i++) begin
         rowq[i].delete();
         first_rise[i] = -1;
         nxt_v[i] = 0;
         nxt_d[i] = 32'd0;
      end

      @(negedge clk);
      start = 1'b1;
      sub_scale_M = 8'(m);
      sub_scale_P = 8'(p);
      @(negedge clk);
      start = 1'b0;

      idx = 0;
      while (xfers < mp) begin
         check_val({name, ":in_ready_load"}, in_ready, 1);
         check_val({name, ":valid_load"}, vp, 0);
         start = start_in_load && (idx == 2);
         if (start) begin
            sub_scale_M = 8'd2;
            sub_scale_P = 8'd5;
         end
         case (vmode)
            0:       in_valid = 1'b1;
            1:       in_valid = (idx % 2 == 0);
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         in_data = seq_data ? 32'(xfers) : $urandom;
         mult_ready = 1'($urandom_range(0, 1));
         if (in_valid) begin
            rowq[xfers % p].push_back(in_data);
            xfers++;
         end
         idx++;
         @(negedge clk);
      end
      start = 1'b0;
      in_valid = 1'b0;

      for (idx = 0; idx < 300 && !finished; idx++) begin
         check_val({name, ":in_ready_drain"}, in_ready, 0);
         check_val({name, ":feed_done"}, feed_done, 32'(done_nxt));
         for (int i = 0; i < 8; i++) begin
            if (nxt_v[i]) begin
               exp_hold[i] = nxt_d[i];
               if (first_rise[i] < 0) first_rise[i] = idx;
            end
            check_val($sformatf("%s:valid_put%0d", name, i), vp[i], 32'(nxt_v[i]));
            check_val($sformatf("%s:data_put%0d", name, i), dp[i], exp_hold[i]);
         end
         if (done_nxt) begin
            done_idx = idx;
            finished = 1;
         end else if (t == abort_t) begin
            rst = 1'b0;
            #1;
            check_all_zero({name, ":abort"});
            model_reset();
            @(negedge clk);
            rst = 1'b1;
            mult_ready = 1'b1;
            in_valid = 1'b1;
            repeat (2) begin
               @(negedge clk);
               check_all_zero({name, ":idle_after_abort"});
            end
            in_valid = 1'b0;
            aborted = 1;
            finished = 1;
         end else begin
            case (smode)
               0:       mult_ready = 1'b1;
               1:       mult_ready = (idx % 3 != 2);
               default: mult_ready = 1'($urandom_range(0, 1));
            endcase
            done_nxt = 0;
            for (int i = 0; i < 8; i++) nxt_v[i] = 0;
            if (mult_ready) begin
               for (int i = 0; i < p; i++) begin
                  if (t >= i && t < i + m && rowq[i].size() > 0) begin
                     nxt_v[i] = 1;
                     nxt_d[i] = rowq[i].pop_front();
                  end
               end
               if (t == m + p - 2) done_nxt = 1;
               t++;
            end
            @(negedge clk);
         end
      end

      check_val({name, ":drain_finished"}, 32'(finished), 1);
      if (!aborted) begin
         @(negedge clk);
         check_val({name, ":idle_in_ready"}, in_ready, 0);
         check_val({name, ":idle_feed_done"}, feed_done, 0);
         check_val({name, ":idle_valid"}, vp, 0);
         if (smode == 0) begin
            for (int i = 0; i < p; i++)
               check_val($sformatf("%s:first_rise%0d", name, i), 32'(first_rise[i]), 32'(i + 1));
            check_val({name, ":done_cycle"}, 32'(done_idx), 32'(m + p - 1));
         end
      end
   endtask

   task automatic bad_start(input string name, input int m, input int p);
      @(negedge clk);
      start = 1'b1;
      sub_scale_M = 8'(m);
      sub_scale_P = 8'(p);
      in_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         check_val({name, ":in_ready"}, in_ready, 0);
         check_val({name, ":valid"}, vp, 0);
         check_val({name, ":feed_done"}, feed_done, 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("post_reset_idle");

      run_case("m4p8_seq",     4, 8, 0, 0, 1, -1, 0);
      run_case("m3p2_toggle",  3, 2, 1, 0, 1, -1, 0);
      run_case("m16p8_stall", 16, 8, 2, 1, 0, -1, 0);
      bad_start("bad_m0",  0, 8);
      bad_start("bad_m17", 17, 8);
      bad_start("bad_p9",  4, 9);
      run_case("m1p1",         1, 1, 0, 0, 0, -1, 0);
      run_case("m8p8_abort",   8, 8, 2, 0, 0, 2, 0);
      run_case("m2p2_fresh",   2, 2, 2, 0, 0, -1, 0);
      run_case("m4p3_restart", 4, 3, 2, 0, 0, -1, 1);
      for (int k = 0; k < 6; k++)
         run_case($sformatf("rand%0d", k), int'($urandom_range(1, 16)), int'($urandom_range(1, 8)),
                  2, int'($urandom_range(0, 2)), 0, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
